// File: rtl/prbs_pkg.sv
// Shared types and default PRBS7 constants for the XNOR pattern generator.
package prbs_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } prbs_state_e;

  localparam int         PRBS7_LEN    = 7;
  localparam int         PRBS7_TAP_A  = 6;
  localparam int         PRBS7_TAP_B  = 5;
  // XNOR feedback never leaves the all-ones state.
  localparam logic [6:0] PRBS7_LOCKUP = 7'h7F;

endpackage

// File: rtl/prbs_xnor_step.sv
// Combinational advance of an XNOR-feedback LFSR by LANES steps.
// bits[0] is the bit shifted out by the first (earliest) step.
module prbs_xnor_step #(
  parameter int LANES = 2,
  parameter int LEN   = 7,
  parameter int TAP_A = 6,
  parameter int TAP_B = 5
) (
  input  logic [LEN-1:0]   lfsr_in,
  output logic [LEN-1:0]   lfsr_out,
  output logic [LANES-1:0] bits
);

  // Unrolled shift chain, one iteration per emitted lane.
  always_comb begin
    logic [LEN-1:0] st_s;
    st_s = lfsr_in;
    bits = '0;
    for (int i = 0; i < LANES; i++) begin
      bits[i] = st_s[LEN-1];
      st_s    = {st_s[LEN-2:0], ~(st_s[TAP_A] ^ st_s[TAP_B])};
    end
    lfsr_out = st_s;
  end

endmodule

// File: rtl/prbs_xnor_gen.sv
// Burst PRBS transmitter over valid/ready using an XNOR LFSR.
// Optional PRBS_ERR_INJ_EN adds err_inj to flip lane0 of the following beat.
module prbs_xnor_gen
  import prbs_pkg::*;
#(
  parameter int LANES   = 2,
  parameter int LEN     = PRBS7_LEN,
  parameter int TAP_A   = PRBS7_TAP_A,
  parameter int TAP_B   = PRBS7_TAP_B,
  parameter int BURST_W = 8
) (
  input  logic               CLKIN,
  input  logic               RESETN,
  input  logic               start,
  input  logic               seed_load,
  input  logic [LEN-1:0]     seed,
  input  logic [BURST_W-1:0] burst_len,
  input  logic               out_ready,
`ifdef PRBS_ERR_INJ_EN
  input  logic               err_inj,
`endif
  output logic               out_valid,
  output logic [LANES-1:0]   out_data,
  output logic               busy,
  output logic               done
);

  localparam logic [LEN-1:0]     LOCKUP    = {LEN{1'b1}};
  localparam logic [BURST_W-1:0] COUNT_ONE = BURST_W'(1);

  prbs_state_e        state_r, state_nxt_s;
  logic [LEN-1:0]     lfsr_r, lfsr_nxt_s;
  logic [BURST_W-1:0] count_r, count_nxt_s;
  logic               valid_r, valid_nxt_s;
  logic [LANES-1:0]   data_r, data_nxt_s;
  logic               busy_r, done_r, done_nxt_s;

  logic [LEN-1:0]     seed_fix_s, step_in_s, step_lfsr_s;
  logic [LANES-1:0]   step_bits_s, inj_mask_s;

  assign seed_fix_s = (seed == LOCKUP) ? '0 : seed;
  // A seed loaded together with start must feed the first beat.
  assign step_in_s  = ((state_r == IDLE) && seed_load) ? seed_fix_s : lfsr_r;

`ifdef PRBS_ERR_INJ_EN
  assign inj_mask_s = LANES'(err_inj);
`else
  assign inj_mask_s = '0;
`endif

  prbs_xnor_step #(
    .LANES (LANES),
    .LEN   (LEN),
    .TAP_A (TAP_A),
    .TAP_B (TAP_B)
  ) u_step (
    .lfsr_in  (step_in_s),
    .lfsr_out (step_lfsr_s),
    .bits     (step_bits_s)
  );

  // Next-state and next-output logic for the burst FSM.
  always_comb begin
    state_nxt_s = state_r;
    lfsr_nxt_s  = lfsr_r;
    count_nxt_s = count_r;
    valid_nxt_s = valid_r;
    data_nxt_s  = data_r;
    done_nxt_s  = 1'b0;
    case (state_r)
      IDLE: begin
        if (seed_load) begin
          lfsr_nxt_s = seed_fix_s;
        end else begin
          lfsr_nxt_s = lfsr_r;
        end
        if (start) begin
          count_nxt_s = burst_len;
          if (burst_len == '0) begin
            state_nxt_s = DONE;
            done_nxt_s  = 1'b1;
          end else begin
            state_nxt_s = RUN;
            valid_nxt_s = 1'b1;
            data_nxt_s  = step_bits_s;
            lfsr_nxt_s  = step_lfsr_s;
          end
        end else begin
          count_nxt_s = count_r;
        end
      end
      RUN: begin
        if (valid_r && out_ready) begin
          count_nxt_s = count_r - COUNT_ONE;
          // The last beat leaves lfsr untouched so the next burst continues the sequence.
          if (count_r == COUNT_ONE) begin
            state_nxt_s = DONE;
            valid_nxt_s = 1'b0;
            done_nxt_s  = 1'b1;
          end else begin
            data_nxt_s  = step_bits_s ^ inj_mask_s;
            lfsr_nxt_s  = step_lfsr_s;
          end
        end else begin
          valid_nxt_s = valid_r;
        end
      end
      DONE: begin
        state_nxt_s = IDLE;
      end
      default: begin
        state_nxt_s = IDLE;
        valid_nxt_s = 1'b0;
      end
    endcase
  end

  // State, counter and output registers.
  always_ff @(posedge CLKIN or negedge RESETN) begin
    if (!RESETN) begin
      state_r <= IDLE;
      lfsr_r  <= '0;
      count_r <= '0;
      valid_r <= 1'b0;
      data_r  <= '0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      lfsr_r  <= lfsr_nxt_s;
      count_r <= count_nxt_s;
      valid_r <= valid_nxt_s;
      data_r  <= data_nxt_s;
      busy_r  <= (state_nxt_s == RUN);
      done_r  <= done_nxt_s;
    end
  end

  assign out_valid = valid_r;
  assign out_data  = data_r;
  assign busy      = busy_r;
  assign done      = done_r;

endmodule
